// File: rtl/spi_pkg.sv
// Shared constants for the oversampled SPI responder.
// State encoding, default word width and the underrun fill value.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef logic [1:0] spi_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Bit replicated across the tx shift register when no word is waiting.
  localparam logic UNDERRUN_BIT = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// Mode-0 SPI responder clocked entirely by clk; sck/ss/mosi are oversampled.
// Optional SPI_SLAVE_OVERRUN_EN adds rx_ack / sticky rx_ovr.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic              rx_ack,
  output logic              rx_ovr
`endif
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic ss_s, ss_rise, ss_fall;
  logic sck_s, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst(rst), .d(ss), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= '0;
    else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  spi_state_t        state;
  logic [DATA_W-1:0] hold, tx_sh, rx_sh, fill_word;
  logic              hold_full;
  logic [CW-1:0]     cnt;
  logic              reload, word_done;

  assign miso_oe   = ss_s;
  assign tx_ready  = ~hold_full;
  assign fill_word = hold_full ? hold : {DATA_W{UNDERRUN_BIT}};

  // A word boundary fall reloads like LOAD, unless ss is leaving (holding word kept).
  assign reload    = (state == ST_LOAD && !ss_fall) ||
                     (state == ST_SHIFT && sck_fall && cnt == '0 && !ss_fall);
  assign word_done = (state == ST_SHIFT) && sck_rise && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end else if (reload && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cnt      <= '0;
      miso     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (reload) begin
        tx_sh <= fill_word;
        miso  <= fill_word[DATA_W-1];
      end
      case (state)
        ST_IDLE: if (ss_rise) state <= ST_LOAD;
        ST_LOAD: begin
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};
            if (word_done) begin
              rx_data  <= {rx_sh[DATA_W-2:0], mosi_s};
              rx_valid <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (sck_fall && cnt != '0) begin
            tx_sh <= tx_sh << 1;
            miso  <= tx_sh[DATA_W-2];
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Leaving the frame wins over everything except a word completing this cycle.
      if (ss_fall && state != ST_IDLE) begin
        state <= ST_IDLE;
        cnt   <= '0;
        miso  <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_pending <= 1'b0;
      rx_ovr     <= 1'b0;
    end else begin
      if (word_done)   rx_pending <= 1'b1;
      else if (rx_ack) rx_pending <= 1'b0;
      if (rx_ack)                       rx_ovr <= 1'b0;
      else if (word_done && rx_pending) rx_ovr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: stimulus pushes expected rx words, a monitor checks them.
module tb_spi_slave_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b0, sck = 1'b0, mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       tx_valid = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack = 1'b0;
  logic       rx_ovr;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_sync #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_ack(rx_ack), .rx_ovr(rx_ovr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid pulse pops one expected word; pulses must be one cycle wide.
  initial begin
    logic prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && rx_valid) begin
        check("rx_valid_width", {31'd0, prev_vld}, 32'd0);
        if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      prev_vld = rst & rx_valid;
    end
  end

  task automatic push_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 200) begin @(negedge clk); t++; end
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master: drive mosi while sck low, sample miso just before each rise.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = miso;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] mo, input logic [7:0] exp_mi);
    logic [7:0] mi;
    exp_q.push_back(mo);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    spi_xfer(mo, 8, mi);
    check({name, "_miso"}, {24'd0, mi}, {24'd0, exp_mi});
    repeat (8) @(negedge clk);
    check({name, "_busy_in"}, {31'd0, busy}, 32'd1);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    check({name, "_busy_out"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi0, mi1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso",     {31'd0, miso},     32'd0);
    check("rst_miso_oe",  {31'd0, miso_oe},  32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // single word
    push_tx(8'hA5);
    check("single_tx_ready_lo", {31'd0, tx_ready}, 32'd0);
    run_frame("single", 8'h3C, 8'hA5);
    check("single_tx_ready_hi", {31'd0, tx_ready}, 32'd1);

    // back-to-back
    push_tx(8'h81);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    push_tx(8'h7E);
    spi_xfer(8'h12, 8, mi0);
    spi_xfer(8'h34, 8, mi1);
    check("b2b_miso0", {24'd0, mi0}, 32'h81);
    check("b2b_miso1", {24'd0, mi1}, 32'h7E);
    repeat (8) @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);

    // underrun
    run_frame("underrun", 8'h96, 8'h00);
    check("underrun_tx_ready", {31'd0, tx_ready}, 32'd1);

    // abort after 5 bits
    ss = 1'b1;
    repeat (8) @(negedge clk);
    spi_xfer(8'hFF, 5, mi0);
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_rx_data", {24'd0, rx_data}, 32'h96);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_miso", {31'd0, miso}, 32'd0);
    run_frame("after_abort", 8'h55, 8'h00);

    // async reset mid-frame
    ss = 1'b1;
    repeat (8) @(negedge clk);
    spi_xfer(8'hAA, 3, mi0);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_busy",     {31'd0, busy},     32'd0);
    check("mid_rst_miso_oe",  {31'd0, miso_oe},  32'd0);
    check("mid_rst_rx_data",  {24'd0, rx_data},  32'd0);
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_miso",     {31'd0, miso},     32'd0);
    @(negedge clk);
    ss = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    run_frame("post_rst", 8'hC3, 8'h00);

`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    check("ovr_clear_start", {31'd0, rx_ovr}, 32'd0);
    run_frame("ovr1", 8'h11, 8'h00);
    check("ovr_after_first", {31'd0, rx_ovr}, 32'd0);
    run_frame("ovr2", 8'h22, 8'h00);
    check("ovr_after_second", {31'd0, rx_ovr}, 32'd1);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("ovr_acked", {31'd0, rx_ovr}, 32'd0);
`endif

    repeat (10) @(negedge clk);
    check("rx_words_outstanding", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
